// File: rtl/count_compare_timer.sv
// Compare timer: arms on a target, pulses match when count reaches it (wrap-safe), and
// queues the matching count values in a first-word-fall-through FIFO. Optional macro CCT_LATE_FLAG_EN adds evt_late.
//
//   state | meaning
//   IDLE  | waiting for a config handshake, cfg_ready high
//   ARMED | comparing count against target each cycle
module count_compare_timer #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  count,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [WIDTH-1:0]  cfg_target,
   input  logic [WIDTH-1:0]  cfg_period,
   input  logic              cfg_periodic,
   input  logic              disarm,
   output logic              armed,
   output logic              match,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [WIDTH-1:0]  evt_stamp,
`ifdef CCT_LATE_FLAG_EN
   output logic              evt_late,
`endif
   output logic [DROP_W-1:0] drop_cnt
);

   localparam int AW = $clog2(DEPTH);
`ifdef CCT_LATE_FLAG_EN
   localparam int EW = WIDTH + 1;
`else
   localparam int EW = WIDTH;
`endif

   typedef enum logic {IDLE, ARMED} state_t;

   state_t             state, state_n;
   logic [WIDTH-1:0]   target, period;
   logic               periodic;
   logic signed [WIDTH-1:0] diff;
   logic               hit, push, reload;

   logic [EW-1:0]      mem [DEPTH];
   logic [EW-1:0]      entry, head, last;
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [AW:0]        occ;
   logic               full, pop, wr_en, drop;

   // Reached-or-passed test: the modular difference read as signed is non-negative.
   assign diff   = count - target;
   assign hit    = (state == ARMED) && (diff >= 0);
   assign push   = hit && !disarm;
   assign reload = periodic && (period != '0);

   assign armed     = (state == ARMED);
   assign cfg_ready = (state == IDLE);

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (cfg_valid) state_n = ARMED;
         ARMED:   if (disarm || (hit && !reload)) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         target   <= '0;
         period   <= '0;
         periodic <= 1'b0;
         match    <= 1'b0;
      end else begin
         state <= state_n;
         match <= push;
         if (state == IDLE && cfg_valid) begin
            target   <= cfg_target;
            period   <= cfg_period;
            periodic <= cfg_periodic;
         end else if (push && reload) begin
            target <= target + period;
         end
      end
   end

`ifdef CCT_LATE_FLAG_EN
   assign entry = {count != target, count};
`else
   assign entry = count;
`endif

   assign evt_valid = (occ != '0);
   assign full      = (occ == (AW+1)'(DEPTH));
   assign pop       = evt_valid && evt_ready;
   assign wr_en     = push && (!full || pop);
   assign drop      = push && full && !pop;
   assign head      = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= entry;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         last     <= '0;
         drop_cnt <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            last   <= head;
         end
         case ({wr_en, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
         if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
   end

   // When empty the output holds the most recently popped entry.
   assign evt_stamp = evt_valid ? head[WIDTH-1:0] : last[WIDTH-1:0];
`ifdef CCT_LATE_FLAG_EN
   assign evt_late  = evt_valid ? head[WIDTH] : last[WIDTH];
`endif

endmodule
